// File: rtl/tron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tron_pkg
//  Description : Shared types, grid defaults and helpers for the Tron rider
//                motion engine (headings, FSM states, winner codes, one-cell
//                head advance with wall detection).
//  Revision    : 1.0 - initial release
// ============================================================================
package tron_pkg;

    localparam int COORD_W     = 10;
    localparam int DEF_GRID_X  = 150;
    localparam int DEF_GRID_Y  = 200;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        OVER = 2'd3
    } state_t;

    // Result of trying to move a head one cell.
    typedef struct packed {
        logic               crash;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } move_t;

    function automatic dir_t opposite(input dir_t d);
        dir_t o;
        case (d)
            UP:      o = DOWN;
            DOWN:    o = UP;
            LEFT:    o = RIGHT;
            default: o = LEFT;
        endcase
        return o;
    endfunction

    // The wall test is done before the arithmetic, so a crashed head keeps
    // its current coordinates and the subtraction never wraps.
    function automatic move_t advance(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y,
                                      input dir_t               d,
                                      input logic [COORD_W-1:0] xmax,
                                      input logic [COORD_W-1:0] ymax);
        move_t m;
        m.crash = 1'b0;
        m.x     = x;
        m.y     = y;
        case (d)
            UP:      if (x == '0)   m.crash = 1'b1; else m.x = x - COORD_W'(1);
            DOWN:    if (x == xmax) m.crash = 1'b1; else m.x = x + COORD_W'(1);
            LEFT:    if (y == '0)   m.crash = 1'b1; else m.y = y - COORD_W'(1);
            default: if (y == ymax) m.crash = 1'b1; else m.y = y + COORD_W'(1);
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tron_player_motion_if.sv
`default_nettype none
// ============================================================================
//  Module      : tron_player_motion_if
//  Description : Link between the motion engine and the trace-update stage.
//                step   - one-cycle strobe, new_* carry candidate heads
//                new_*  - P1/P2 head coordinates (candidate or committed)
//                valid  - trace stage accepts the candidates (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
interface tron_player_motion_if;
    import tron_pkg::*;

    logic               step;
    logic [COORD_W-1:0] new_x1;
    logic [COORD_W-1:0] new_y1;
    logic [COORD_W-1:0] new_x2;
    logic [COORD_W-1:0] new_y2;
    logic               valid;

    modport master (
        output step, new_x1, new_y1, new_x2, new_y2,
        input  valid
    );

    modport slave (
        input  step, new_x1, new_y1, new_x2, new_y2,
        output valid
    );

endinterface
`default_nettype wire

// File: rtl/tron_dir_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tron_dir_latch
//  Description : Per-player heading register. Buttons update a pending
//                heading (priority up > down > left > right, reversals
//                rejected); commit copies pending into the committed heading.
//  Ports       : clock, reset_n (sync, active-low), init (reset heading),
//                btn {up,down,left,right}, enable (accept buttons),
//                commit (tick), pending, committed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tron_dir_latch
    import tron_pkg::*;
(
    input  wire logic       clock,
    input  wire logic       reset_n,
    input  wire dir_t       init,
    input  wire logic [3:0] btn,
    input  wire logic       enable,
    input  wire logic       commit,
    output dir_t            pending,
    output dir_t            committed
);

    dir_t r_pending;
    dir_t r_committed;
    dir_t w_req;
    dir_t w_ref;
    logic w_req_vld;
    logic w_accept;

    always_comb begin
        w_req_vld = |btn;
        w_req     = RIGHT;
        if (btn[3])      w_req = UP;
        else if (btn[2]) w_req = DOWN;
        else if (btn[1]) w_req = LEFT;
        else             w_req = RIGHT;

        // On a commit edge the pending heading becomes the committed one, so
        // reversal is judged against it; otherwise a request could slip in
        // that reverses the heading about to take effect.
        w_ref    = commit ? r_pending : r_committed;
        w_accept = enable && w_req_vld && (w_req != opposite(w_ref));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pending   <= init;
            r_committed <= init;
        end else begin
            if (commit) begin
                r_committed <= r_pending;
            end
            if (w_accept) begin
                r_pending <= w_req;
            end
        end
    end

    assign pending   = r_pending;
    assign committed = r_committed;

endmodule
`default_nettype wire

// File: rtl/tron_player_motion.sv
`default_nettype none
// ============================================================================
//  Module      : tron_player_motion
//  Description : Per-tick motion engine for both Tron riders. Latches button
//                headings, advances each head one cell per tick, offers the
//                candidates to the trace stage and commits them on valid,
//                detecting wall / head-on / trace crashes.
//  Ports       : clock, reset_n (sync, active-low), start (level),
//                p1_btn/p2_btn {up,down,left,right},
//                trace (step/new_x1/new_y1/new_x2/new_y2 out, valid in),
//                game_over, winner (00 none, 01 P1, 10 P2, 11 draw).
//  Revision    : 1.0 - initial release
// ============================================================================
module tron_player_motion
    import tron_pkg::*;
#(
    parameter int GRID_X      = DEF_GRID_X,
    parameter int GRID_Y      = DEF_GRID_Y,
    parameter int TICK_CYCLES = 2_500_000,
    parameter int P1_X0       = 75,
    parameter int P1_Y0       = 20,
    parameter int P2_X0       = 75,
    parameter int P2_Y0       = 179
)
(
    input  wire logic       clock,
    input  wire logic       reset_n,
    input  wire logic       start,
    input  wire logic [3:0] p1_btn,
    input  wire logic [3:0] p2_btn,
    tron_player_motion_if.master trace,
    output logic            game_over,
    output logic [1:0]      winner
);

    localparam int                 CNT_W       = $clog2(TICK_CYCLES);
    localparam logic [CNT_W-1:0]   c_tick_last = CNT_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_cnt_one   = CNT_W'(1);
    localparam logic [COORD_W-1:0] c_xmax      = COORD_W'(GRID_X - 1);
    localparam logic [COORD_W-1:0] c_ymax      = COORD_W'(GRID_Y - 1);
    localparam logic [COORD_W-1:0] c_p1_x0     = COORD_W'(P1_X0);
    localparam logic [COORD_W-1:0] c_p1_y0     = COORD_W'(P1_Y0);
    localparam logic [COORD_W-1:0] c_p2_x0     = COORD_W'(P2_X0);
    localparam logic [COORD_W-1:0] c_p2_y0     = COORD_W'(P2_Y0);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_step;
    logic               r_game_over;
    winner_t            r_winner;
    // Committed heads.
    logic [COORD_W-1:0] r_x1, r_y1, r_x2, r_y2;
    // Output heads: candidates during STEP, committed heads otherwise.
    logic [COORD_W-1:0] r_nx1, r_ny1, r_nx2, r_ny2;
    logic               r_crash1, r_crash2;

    dir_t    w_p1_pend, w_p1_comm, w_p2_pend, w_p2_comm;
    dir_t    w_h1, w_h2;
    move_t   w_mv1, w_mv2;
    logic    w_tick;
    logic    w_run;
    logic    w_lat_rst_n;
    logic    w_fail;
    winner_t w_win;

    assign w_run  = (r_state == RUN);
    assign w_tick = w_run && (r_cnt == c_tick_last);
    // Headings return to their start values whenever the engine sits in IDLE.
    assign w_lat_rst_n = reset_n && (r_state != IDLE);

    tron_dir_latch u_dir_p1 (
        .clock     (clock),
        .reset_n   (w_lat_rst_n),
        .init      (RIGHT),
        .btn       (p1_btn),
        .enable    (w_run),
        .commit    (w_tick),
        .pending   (w_p1_pend),
        .committed (w_p1_comm)
    );

    tron_dir_latch u_dir_p2 (
        .clock     (clock),
        .reset_n   (w_lat_rst_n),
        .init      (LEFT),
        .btn       (p2_btn),
        .enable    (w_run),
        .commit    (w_tick),
        .pending   (w_p2_pend),
        .committed (w_p2_comm)
    );

    // Heading in force after this edge: the pending one on a tick.
    assign w_h1  = w_tick ? w_p1_pend : w_p1_comm;
    assign w_h2  = w_tick ? w_p2_pend : w_p2_comm;
    assign w_mv1 = advance(r_x1, r_y1, w_h1, c_xmax, c_ymax);
    assign w_mv2 = advance(r_x2, r_y2, w_h2, c_xmax, c_ymax);

    // Outcome of the STEP cycle; first matching rule wins.
    always_comb begin
        w_fail = 1'b1;
        w_win  = WIN_DRAW;
        if (r_crash1 && r_crash2) begin
            w_win = WIN_DRAW;
        end else if (r_crash1) begin
            w_win = WIN_P2;
        end else if (r_crash2) begin
            w_win = WIN_P1;
        end else if ((r_nx1 == r_nx2) && (r_ny1 == r_ny2)) begin
            w_win = WIN_DRAW;
        end else if (!trace.valid) begin
            w_win = WIN_DRAW;
        end else begin
            w_fail = 1'b0;
            w_win  = WIN_NONE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_step      <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= WIN_NONE;
            r_x1        <= c_p1_x0;
            r_y1        <= c_p1_y0;
            r_x2        <= c_p2_x0;
            r_y2        <= c_p2_y0;
            r_nx1       <= c_p1_x0;
            r_ny1       <= c_p1_y0;
            r_nx2       <= c_p2_x0;
            r_ny2       <= c_p2_y0;
            r_crash1    <= 1'b0;
            r_crash2    <= 1'b0;
        end else begin
            r_step <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt       <= '0;
                    r_game_over <= 1'b0;
                    r_winner    <= WIN_NONE;
                    r_x1        <= c_p1_x0;
                    r_y1        <= c_p1_y0;
                    r_x2        <= c_p2_x0;
                    r_y2        <= c_p2_y0;
                    r_nx1       <= c_p1_x0;
                    r_ny1       <= c_p1_y0;
                    r_nx2       <= c_p2_x0;
                    r_ny2       <= c_p2_y0;
                    if (start) begin
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    if (w_tick) begin
                        r_cnt    <= '0;
                        r_state  <= STEP;
                        r_step   <= 1'b1;
                        r_nx1    <= w_mv1.x;
                        r_ny1    <= w_mv1.y;
                        r_nx2    <= w_mv2.x;
                        r_ny2    <= w_mv2.y;
                        r_crash1 <= w_mv1.crash;
                        r_crash2 <= w_mv2.crash;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                STEP: begin
                    // The STEP cycle is count 0 of the next tick period, so
                    // steps stay exactly TICK_CYCLES apart.
                    r_cnt <= r_cnt + c_cnt_one;
                    if (w_fail) begin
                        r_state     <= OVER;
                        r_game_over <= 1'b1;
                        r_winner    <= w_win;
                        r_nx1       <= r_x1;
                        r_ny1       <= r_y1;
                        r_nx2       <= r_x2;
                        r_ny2       <= r_y2;
                    end else begin
                        r_state <= RUN;
                        r_x1    <= r_nx1;
                        r_y1    <= r_ny1;
                        r_x2    <= r_nx2;
                        r_y2    <= r_ny2;
                    end
                end

                OVER: begin
                    if (start) begin
                        r_state     <= IDLE;
                        r_game_over <= 1'b0;
                        r_winner    <= WIN_NONE;
                        r_cnt       <= '0;
                        r_x1        <= c_p1_x0;
                        r_y1        <= c_p1_y0;
                        r_x2        <= c_p2_x0;
                        r_y2        <= c_p2_y0;
                        r_nx1       <= c_p1_x0;
                        r_ny1       <= c_p1_y0;
                        r_nx2       <= c_p2_x0;
                        r_ny2       <= c_p2_y0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign trace.step   = r_step;
    assign trace.new_x1 = r_nx1;
    assign trace.new_y1 = r_ny1;
    assign trace.new_x2 = r_nx2;
    assign trace.new_y2 = r_ny2;
    assign game_over    = r_game_over;
    assign winner       = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_tron_player_motion.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tron_player_motion
//  Description : Directed self-checking bench for tron_player_motion. Three
//                instances with TICK_CYCLES=4: default starts, P1 on the top
//                wall, and riders one cell apart for a head-on collision.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tron_player_motion;

    logic       clk;
    logic       reset_n;
    logic       start_a, start_b, start_c;
    logic [3:0] p1_a, p2_a, p1_b, p2_b, p1_c, p2_c;
    logic       game_over_a, game_over_b, game_over_c;
    logic [1:0] winner_a, winner_b, winner_c;

    int n_checks;
    int n_errors;

    tron_player_motion_if ifa ();
    tron_player_motion_if ifb ();
    tron_player_motion_if ifc ();

    tron_player_motion #(.TICK_CYCLES(4)) dut_a (
        .clock(clk), .reset_n(reset_n), .start(start_a),
        .p1_btn(p1_a), .p2_btn(p2_a), .trace(ifa),
        .game_over(game_over_a), .winner(winner_a)
    );

    tron_player_motion #(.TICK_CYCLES(4), .P1_X0(0)) dut_b (
        .clock(clk), .reset_n(reset_n), .start(start_b),
        .p1_btn(p1_b), .p2_btn(p2_b), .trace(ifb),
        .game_over(game_over_b), .winner(winner_b)
    );

    tron_player_motion #(.TICK_CYCLES(4), .P1_Y0(99), .P2_Y0(101)) dut_c (
        .clock(clk), .reset_n(reset_n), .start(start_c),
        .p1_btn(p1_c), .p2_btn(p2_c), .trace(ifc),
        .game_over(game_over_c), .winner(winner_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic cur_step(input int d);
        logic s;
        case (d)
            0:       s = ifa.step;
            1:       s = ifb.step;
            default: s = ifc.step;
        endcase
        return s;
    endfunction

    // Cycles until the selected instance shows step; -1 if the budget expires.
    task automatic wait_step(input int d, input int budget, output int n);
        logic found;
        found = 1'b0;
        n     = -1;
        for (int i = 1; i <= budget && !found; i++) begin
            @(posedge clk);
            #1;
            if (cur_step(d)) begin
                found = 1'b1;
                n     = i;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        start_a  = 1'b0; start_b = 1'b0; start_c = 1'b0;
        p1_a = 4'b0; p2_a = 4'b0; p1_b = 4'b0; p2_b = 4'b0; p1_c = 4'b0; p2_c = 4'b0;
        ifa.valid = 1'b1; ifb.valid = 1'b1; ifc.valid = 1'b1;
        cyc(2);
        reset_n = 1'b1;

        // Reset state.
        chk("rst step",   32'(ifa.step),   0);
        chk("rst over",   32'(game_over_a), 0);
        chk("rst winner", 32'(winner_a),   0);
        chk("rst x1",     32'(ifa.new_x1), 75);
        chk("rst y1",     32'(ifa.new_y1), 20);
        chk("rst x2",     32'(ifa.new_x2), 75);
        chk("rst y2",     32'(ifa.new_y2), 179);
        cyc(3);
        chk("idle no step", 32'(ifa.step), 0);

        // Straight-line ticking.
        start_a = 1'b1; cyc(1); start_a = 1'b0;
        wait_step(0, 10, n);
        chk("step1 latency", n, 4);
        chk("step1 x1", 32'(ifa.new_x1), 75);
        chk("step1 y1", 32'(ifa.new_y1), 21);
        chk("step1 y2", 32'(ifa.new_y2), 178);
        wait_step(0, 10, n);
        chk("step2 period", n, 4);
        chk("step2 y1", 32'(ifa.new_y1), 22);
        chk("step2 y2", 32'(ifa.new_y2), 177);
        wait_step(0, 10, n);
        chk("step3 period", n, 4);
        chk("step3 y1", 32'(ifa.new_y1), 23);
        chk("step3 y2", 32'(ifa.new_y2), 176);
        cyc(1);
        chk("post3 step", 32'(ifa.step),   0);
        chk("post3 y1",   32'(ifa.new_y1), 23);
        chk("post3 x2",   32'(ifa.new_x2), 75);
        chk("post3 y2",   32'(ifa.new_y2), 176);
        chk("post3 over", 32'(game_over_a), 0);

        // Up+left together (left is a reversal of RIGHT): up wins; a lone
        // left before the tick is rejected too.
        p1_a = 4'b1010; cyc(1);
        p1_a = 4'b0010; cyc(1);
        p1_a = 4'b0000;
        wait_step(0, 10, n);
        chk("turn latency", n, 1);
        chk("turn x1", 32'(ifa.new_x1), 74);
        chk("turn y1", 32'(ifa.new_y1), 23);
        chk("turn y2", 32'(ifa.new_y2), 175);

        // Down while heading UP is a reversal and is ignored.
        p1_a = 4'b0100;
        wait_step(0, 10, n);
        p1_a = 4'b0000;
        chk("norev period", n, 4);
        chk("norev x1", 32'(ifa.new_x1), 73);
        chk("norev y1", 32'(ifa.new_y1), 23);

        // Reset mid-count in RUN.
        cyc(1);
        reset_n = 1'b0; cyc(1); reset_n = 1'b1;
        chk("mrst step",   32'(ifa.step),   0);
        chk("mrst over",   32'(game_over_a), 0);
        chk("mrst winner", 32'(winner_a),   0);
        chk("mrst x1",     32'(ifa.new_x1), 75);
        chk("mrst y1",     32'(ifa.new_y1), 20);
        chk("mrst x2",     32'(ifa.new_x2), 75);
        chk("mrst y2",     32'(ifa.new_y2), 179);
        cyc(3);
        chk("mrst idle", 32'(ifa.step), 0);
        start_a = 1'b1; cyc(1); start_a = 1'b0;
        wait_step(0, 10, n);
        chk("restart latency", n, 4);
        chk("restart y1", 32'(ifa.new_y1), 21);
        chk("restart y2", 32'(ifa.new_y2), 178);

        // Trace stage rejects the second step.
        cyc(1);
        ifa.valid = 1'b0;
        wait_step(0, 10, n);
        chk("nv period", n, 3);
        chk("nv cand y1", 32'(ifa.new_y1), 22);
        chk("nv cand y2", 32'(ifa.new_y2), 177);
        cyc(1);
        chk("nv over",   32'(game_over_a), 1);
        chk("nv winner", 32'(winner_a),   3);
        chk("nv step",   32'(ifa.step),   0);
        chk("nv x1",     32'(ifa.new_x1), 75);
        chk("nv y1",     32'(ifa.new_y1), 21);
        chk("nv x2",     32'(ifa.new_x2), 75);
        chk("nv y2",     32'(ifa.new_y2), 178);
        ifa.valid = 1'b1;
        cyc(5);
        chk("frozen winner", 32'(winner_a),   3);
        chk("frozen over",   32'(game_over_a), 1);
        chk("frozen step",   32'(ifa.step),   0);
        chk("frozen y1",     32'(ifa.new_y1), 21);
        start_a = 1'b1; cyc(1); start_a = 1'b0;
        chk("to idle over",   32'(game_over_a), 0);
        chk("to idle winner", 32'(winner_a),   0);
        chk("to idle y1",     32'(ifa.new_y1), 20);
        chk("to idle y2",     32'(ifa.new_y2), 179);
        cyc(6);
        chk("stay idle step", 32'(ifa.step),   0);
        chk("stay idle y1",   32'(ifa.new_y1), 20);

        // P1 heading UP from row 0 hits the wall on the first step.
        start_b = 1'b1; p1_b = 4'b1000; cyc(1); start_b = 1'b0;
        wait_step(1, 10, n);
        chk("wall latency", n, 4);
        chk("wall cand x1", 32'(ifb.new_x1), 0);
        chk("wall cand y1", 32'(ifb.new_y1), 20);
        chk("wall cand y2", 32'(ifb.new_y2), 178);
        p1_b = 4'b0000;
        cyc(1);
        chk("wall over",   32'(game_over_b), 1);
        chk("wall winner", 32'(winner_b),   2);
        chk("wall x1",     32'(ifb.new_x1), 0);
        chk("wall y2",     32'(ifb.new_y2), 179);
        cyc(3);
        chk("wall x1 hold", 32'(ifb.new_x1), 0);

        // Head-on collision at column 100.
        start_c = 1'b1; cyc(1); start_c = 1'b0;
        wait_step(2, 10, n);
        chk("headon latency", n, 4);
        chk("headon cand y1", 32'(ifc.new_y1), 100);
        chk("headon cand y2", 32'(ifc.new_y2), 100);
        cyc(1);
        chk("headon over",   32'(game_over_c), 1);
        chk("headon winner", 32'(winner_c),   3);
        chk("headon y1",     32'(ifc.new_y1), 99);
        chk("headon y2",     32'(ifc.new_y2), 101);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tron_player_motion.md
Name: tron_player_motion

Overview:
- Per-tick motion engine for both Tron riders.
- Converts button inputs into a registered heading per player and advances each head one cell per game tick.
- Drives the candidate head coordinates into the trace-update stage and commits them only when that stage returns valid.
- Detects wall and head-on crashes and reports game over with a winner code.

Parameters:
- GRID_X, 150, row count; x range 0..GRID_X-1.
- GRID_Y, 200, column count; y range 0..GRID_Y-1.
- TICK_CYCLES, 2_500_000, clock cycles per move (10 moves/s at 25 MHz). Minimum 2.
- P1_X0, 75, P1 start row.
- P1_Y0, 20, P1 start column; P1 start heading is RIGHT.
- P2_X0, 75, P2 start row.
- P2_Y0, 179, P2 start column; P2 start heading is LEFT.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  level; begins a round from IDLE or OVER
- p1_btn  in  4  {up,down,left,right} heading requests, level
- p2_btn  in  4  same for P2
- valid  in  1  from trace-update stage: candidate moves accepted
- step  out  1  one-cycle strobe; new_* hold candidate moves
- new_x1, new_y1  out  10 each  P1 head: candidate during step, committed otherwise
- new_x2, new_y2  out  10 each  P2 head, same rules as P1
- game_over  out  1  high while in OVER
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw

Behaviour:
- Clock and reset: one clock domain, clock. reset_n is synchronous and active-low.
- Reset values:
  - state = IDLE; step = 0; game_over = 0; winner = 00.
  - Heads at (P1_X0,P1_Y0) and (P2_X0,P2_Y0).
  - Headings P1 = RIGHT, P2 = LEFT; pending headings equal committed headings; tick counter = 0.
- Heading geometry:
  - UP: x-1. DOWN: x+1. LEFT: y-1. RIGHT: y+1.
  - All coordinate arithmetic is 10-bit unsigned. Crash checks happen before arithmetic, so no wrap-around ever occurs.
- Pending heading, per player, updated every cycle in RUN:
  - If multiple buttons are set, priority is up > down > left > right.
  - A request opposite to the committed heading is ignored (no reversal).
  - With no button set, the pending heading is held.
  - At each tick the pending heading becomes the committed heading.
- States:
  - IDLE:
    - Heads at start positions, winner = 00, counter cleared.
    - start=1 -> RUN.
  - RUN:
    - Counter increments each cycle.
    - At count TICK_CYCLES-1: counter -> 0, commit pending headings, compute candidates, go to STEP.
  - STEP, exactly one cycle:
    - step = 1 and new_* show the candidates.
    - Wall crash per player: x==0 & UP, x==GRID_X-1 & DOWN, y==0 & LEFT, y==GRID_Y-1 & RIGHT. For a wall-crashed player, the candidate equals the current head.
    - Resolution, first match wins:
      1. Both players wall-crashed -> winner 11.
      2. Only P1 wall-crashed -> winner 10.
      3. Only P2 wall-crashed -> winner 01.
      4. Candidates equal (head-on) -> winner 11.
      5. valid = 0 -> winner 11 (trace collision).
      6. Otherwise commit the candidates and go to RUN.
    - Cases 1-5 go to OVER.
    - valid is sampled in this same cycle; the downstream stage is combinational.
  - OVER:
    - game_over = 1; heads and winner frozen.
    - start=1 -> IDLE on the next cycle. The round restarts only after another start.
- Outside STEP: new_* equal the committed heads and step = 0.
- Reset mid-round: returns to IDLE with all reset values on the next edge, regardless of state.
- start while in RUN or STEP is ignored.
- Latency: a button pressed at least one cycle before the tick edge takes effect on that tick's move.

Decomposition:
- tron_pkg:
  - dir_t enum {UP,DOWN,LEFT,RIGHT}
  - winner_t (2-bit codes)
  - state_t {IDLE,RUN,STEP,OVER}
  - GRID_X / GRID_Y defaults
  - opposite() function
- Sub-module tron_dir_latch, instantiated twice:
  - Inputs: clock, reset_n, init heading, btn[3:0], enable, commit.
  - Outputs: pending heading and committed heading.
  - Implements priority and reversal rejection.

Test Plan:
- TICK_CYCLES=4, valid tied 1, start pulse, no buttons:
  - step fires every 4 cycles.
  - After 3 steps, P1 = (75,23) and P2 = (75,176).
  - game_over = 0.
- P1 holds left (reversal) and up together one cycle before a tick:
  - up wins.
  - Next step P1 = (74,y); a lone left request afterwards is also ignored.
- P1 heading UP started at x=0 (override P1_X0=0):
  - first STEP -> OVER, winner = 10.
  - new_x1 stays 0; no underflow to 1023.
- P1_Y0=99, P2_Y0=101, same row:
  - Step 1 gives 100/100, head-on -> OVER, winner = 11.
- valid forced 0 during the 2nd STEP:
  - OVER, winner = 11.
  - Heads hold the step-1 values (75,21) and (75,178).
- reset_n low for one cycle during RUN mid-count:
  - Next cycle IDLE, heads at start positions, step = 0, counter = 0.
  - A later start resumes normal ticking.
